// File: rtl/ctr_arb_pkg.sv
// Shared types for the AES-256-CTR stream arbiter.
// Holds the arbiter FSM encoding and the stream-id width helper.
package ctr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    // Stream id width: at least one bit even for a two-requester build.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_id_fifo.sv
// Synchronous FIFO of granted stream ids.
// Entry order equals packet order inside the core, so the head owns the return.
module stream_id_fifo
    import ctr_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; simultaneous push and pop keep count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ctr_stream_arbiter.sv
// Packet-level round-robin arbiter in front of one AES-256-CTR core.
// Forward path locks a requester per packet; return path routes by id FIFO.
module ctr_stream_arbiter
    import ctr_arb_pkg::*;
#(
    parameter int NUM_STREAMS   = 4,
    parameter int DATA_WIDTH    = 128,
    parameter int ID_FIFO_DEPTH = 8,
    parameter int ID_W          = id_w(NUM_STREAMS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_STREAMS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_STREAMS-1:0]            s_axis_tvalid,
    input  logic [NUM_STREAMS-1:0]            s_axis_tlast,
    output logic [NUM_STREAMS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic [ID_W-1:0]                   m_axis_tuser,
    input  logic                              m_axis_tready,
    input  logic [DATA_WIDTH-1:0]             c_axis_tdata,
    input  logic                              c_axis_tvalid,
    input  logic                              c_axis_tlast,
    output logic                              c_axis_tready,
    output logic [NUM_STREAMS*DATA_WIDTH-1:0] o_axis_tdata,
    output logic [NUM_STREAMS-1:0]            o_axis_tvalid,
    output logic [NUM_STREAMS-1:0]            o_axis_tlast,
    input  logic [NUM_STREAMS-1:0]            o_axis_tready,
    output logic                              busy,
    output logic                              protocol_err
);

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_STREAMS - 1);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] grant_d;
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] last_grant_d;
    logic            perr_q;
    logic            perr_d;

    logic [ID_W-1:0] winner;
    logic            found;
    int              idx;

    logic            fifo_push;
    logic            fifo_pop;
    logic [ID_W-1:0] fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ret_ok;
    logic            m_hs;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_STREAMS; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_STREAMS;
            if (!found && s_axis_tvalid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Forward FSM next state and the locked-stream mux controls.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        fifo_push     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        m_hs          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found && !fifo_full && !rst) begin
                    grant_d   = winner;
                    fifo_push = 1'b1;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                state_d = LOCK;
            end
            LOCK: begin
                if (!rst) begin
                    m_axis_tvalid          = s_axis_tvalid[grant_q];
                    m_axis_tlast           = s_axis_tlast[grant_q];
                    s_axis_tready[grant_q] = m_axis_tready;
                end
                m_hs = m_axis_tvalid && m_axis_tready;
                if (m_hs && m_axis_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_axis_tdata = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign m_axis_tuser = grant_q;
    assign busy         = (state_q != IDLE) && !rst;

    // Return path: the oldest outstanding id owns the core output.
    always_comb begin
        ret_ok        = !fifo_empty && !rst;
        o_axis_tvalid = '0;
        o_axis_tlast  = '0;
        c_axis_tready = 1'b0;
        if (ret_ok) begin
            o_axis_tvalid[fifo_head] = c_axis_tvalid;
            o_axis_tlast[fifo_head]  = c_axis_tlast;
            c_axis_tready            = o_axis_tready[fifo_head];
        end
        fifo_pop = c_axis_tvalid && c_axis_tready && c_axis_tlast;
    end

    assign o_axis_tdata = {NUM_STREAMS{c_axis_tdata}};

    // Ciphertext arriving with nothing outstanding is a sticky core fault.
    always_comb begin
        perr_d = perr_q || (c_axis_tvalid && fifo_empty);
    end

    assign protocol_err = perr_q;

    // Arbiter state registers; reset drops any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            perr_q       <= perr_d;
        end
    end

    stream_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (grant_d),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_ctr_stream_arbiter.sv
// Directed bench for ctr_stream_arbiter: 4 streams, 32-bit beats,
// two-entry id FIFO so the full condition is reachable.
module tb_ctr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int FD = 2;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [IW-1:0]   m_tuser;
    logic            m_tready;
    logic [DW-1:0]   c_tdata;
    logic            c_tvalid;
    logic            c_tlast;
    logic            c_tready;
    logic [N*DW-1:0] o_tdata;
    logic [N-1:0]    o_tvalid;
    logic [N-1:0]    o_tlast;
    logic [N-1:0]    o_tready;
    logic            busy;
    logic            perr;

    int ncmp = 0;
    int nerr = 0;

    ctr_stream_arbiter #(
        .NUM_STREAMS   (N),
        .DATA_WIDTH    (DW),
        .ID_FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .c_axis_tdata  (c_tdata),
        .c_axis_tvalid (c_tvalid),
        .c_axis_tlast  (c_tlast),
        .c_axis_tready (c_tready),
        .o_axis_tdata  (o_tdata),
        .o_axis_tvalid (o_tvalid),
        .o_axis_tlast  (o_tlast),
        .o_axis_tready (o_tready),
        .busy          (busy),
        .protocol_err  (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int id;
        rst      = 1'b1;
        s_tdata  = {32'hD000_0003, 32'hD000_0002,
                    32'hD000_0001, 32'hD000_0000};
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        c_tdata  = '0;
        c_tvalid = 1'b0;
        c_tlast  = 1'b0;
        o_tready = '1;

        // Reset: outputs quiet during and one cycle after.
        tick();
        s_tvalid = '1;
        settle();
        chk("rst_sready", 64'(s_tready), 64'h0);
        chk("rst_mvalid", 64'(m_tvalid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ctready", 64'(c_tready), 64'h0);
        tick();
        rst      = 1'b0;
        s_tvalid = '0;
        settle();
        chk("post_rst_sready", 64'(s_tready), 64'h0);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_perr", 64'(perr), 64'h0);
        chk("post_rst_ovalid", 64'(o_tvalid), 64'h0);
        tick();

        // Round-robin order 0,1,2,3,0 with 2-beat packets.
        for (int k = 0; k < 5; k++) begin
            id       = k % 4;
            s_tvalid = 4'hF;
            s_tlast  = 4'h0;
            c_tvalid = 1'b0;
            settle();
            chk("rr_idle_busy", 64'(busy), 64'h0);
            chk("rr_idle_mvalid", 64'(m_tvalid), 64'h0);
            tick();
            settle();
            chk("rr_grant_busy", 64'(busy), 64'h1);
            chk("rr_grant_mvalid", 64'(m_tvalid), 64'h0);
            chk("rr_grant_sready", 64'(s_tready), 64'h0);
            tick();
            c_tvalid = 1'b1;
            c_tlast  = 1'b1;
            c_tdata  = 32'hC0DE_0000 + 32'(k);
            settle();
            chk("rr_mvalid", 64'(m_tvalid), 64'h1);
            chk("rr_tuser", 64'(m_tuser), 64'(id));
            chk("rr_mdata", 64'(m_tdata), 64'(32'hD000_0000 + 32'(id)));
            chk("rr_mlast0", 64'(m_tlast), 64'h0);
            chk("rr_sready", 64'(s_tready), 64'(4'b1 << id));
            chk("rr_ovalid", 64'(o_tvalid), 64'(4'b1 << id));
            chk("rr_olast", 64'(o_tlast), 64'(4'b1 << id));
            chk("rr_ctready", 64'(c_tready), 64'h1);
            chk("rr_odata", 64'(o_tdata[id*DW +: DW]),
                64'(32'hC0DE_0000 + 32'(k)));
            tick();
            c_tvalid = 1'b0;
            s_tlast  = 4'hF;
            settle();
            chk("rr_mlast1", 64'(m_tlast), 64'h1);
            chk("rr_sready2", 64'(s_tready), 64'(4'b1 << id));
            tick();
        end

        // Stream 2 five-beat packet; stream 1 requests mid-packet.
        s_tvalid = 4'b0100;
        s_tlast  = 4'b0000;
        tick();
        tick();
        for (int b = 1; b <= 5; b++) begin
            s_tvalid = (b >= 2) ? 4'b0110 : 4'b0100;
            s_tlast  = (b == 5) ? 4'b0100 : 4'b0000;
            settle();
            chk("lock_tuser", 64'(m_tuser), 64'h2);
            chk("lock_sready", 64'(s_tready), 64'h4);
            chk("lock_mlast", 64'(m_tlast), 64'(b == 5));
            tick();
        end
        s_tvalid = 4'b0010;
        s_tlast  = 4'b0010;
        settle();
        chk("s1_idle_busy", 64'(busy), 64'h0);
        tick();
        tick();
        settle();
        chk("s1_tuser", 64'(m_tuser), 64'h1);
        chk("s1_single_last", 64'(m_tlast), 64'h1);
        chk("s1_sready", 64'(s_tready), 64'h2);
        tick();

        // FIFO holds [2,1] and is full; return path stalled.
        s_tvalid = 4'b1000;
        s_tlast  = 4'b1000;
        o_tready = 4'h0;
        c_tvalid = 1'b1;
        c_tlast  = 1'b1;
        c_tdata  = 32'hBEEF_0002;
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("full_busy", 64'(busy), 64'h0);
            chk("full_ctready", 64'(c_tready), 64'h0);
            chk("full_ovalid", 64'(o_tvalid), 64'h4);
            tick();
        end
        o_tready = 4'hF;
        settle();
        chk("pop2_ctready", 64'(c_tready), 64'h1);
        chk("pop2_ovalid", 64'(o_tvalid), 64'h4);
        chk("pop2_busy", 64'(busy), 64'h0);
        tick();
        c_tdata = 32'hBEEF_0001;
        settle();
        chk("pushpop_busy", 64'(busy), 64'h0);
        chk("pushpop_ovalid", 64'(o_tvalid), 64'h2);
        chk("pushpop_ctready", 64'(c_tready), 64'h1);
        tick();
        c_tdata = 32'hBEEF_0003;
        settle();
        chk("s3_grant_busy", 64'(busy), 64'h1);
        chk("s3_ret_ovalid", 64'(o_tvalid), 64'h8);
        chk("s3_ret_odata", 64'(o_tdata[3*DW +: DW]), 64'hBEEF_0003);
        tick();
        c_tvalid = 1'b0;
        settle();
        chk("s3_tuser", 64'(m_tuser), 64'h3);
        chk("s3_mlast", 64'(m_tlast), 64'h1);
        chk("perr_clean", 64'(perr), 64'h0);
        tick();

        // Ciphertext with empty FIFO is a protocol error, sticky.
        s_tvalid = 4'b0000;
        s_tlast  = 4'b0000;
        c_tvalid = 1'b1;
        settle();
        chk("empty_ctready", 64'(c_tready), 64'h0);
        chk("empty_ovalid", 64'(o_tvalid), 64'h0);
        chk("perr_pre", 64'(perr), 64'h0);
        tick();
        c_tvalid = 1'b0;
        settle();
        chk("perr_set", 64'(perr), 64'h1);
        tick();
        settle();
        chk("perr_sticky", 64'(perr), 64'h1);

        // Stream 0 single beat moves last_grant to 0.
        s_tvalid = 4'b0001;
        s_tlast  = 4'b0001;
        tick();
        tick();
        c_tvalid = 1'b1;
        c_tlast  = 1'b1;
        settle();
        chk("s0_tuser", 64'(m_tuser), 64'h0);
        chk("s0_ovalid", 64'(o_tvalid), 64'h1);
        tick();

        // Stream 1 eight-beat packet, reset at beat 3.
        c_tvalid = 1'b0;
        s_tvalid = 4'b0010;
        s_tlast  = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        settle();
        chk("b3_tuser", 64'(m_tuser), 64'h1);
        chk("b3_sready", 64'(s_tready), 64'h2);
        rst = 1'b1;
        settle();
        chk("mid_rst_sready", 64'(s_tready), 64'h0);
        chk("mid_rst_mvalid", 64'(m_tvalid), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_ctready", 64'(c_tready), 64'h0);
        tick();
        rst      = 1'b0;
        s_tvalid = 4'hF;
        settle();
        chk("after_rst_sready", 64'(s_tready), 64'h0);
        chk("after_rst_mvalid", 64'(m_tvalid), 64'h0);
        chk("after_rst_busy", 64'(busy), 64'h0);
        chk("after_rst_fifo_empty", 64'(c_tready), 64'h0);
        chk("after_rst_perr", 64'(perr), 64'h0);
        tick();
        tick();
        settle();
        chk("after_rst_grant0", 64'(m_tuser), 64'h0);
        chk("after_rst_mvalid1", 64'(m_tvalid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/ctr_stream_arbiter.md
CTR_STREAM_ARBITER -- requirements
Module: ctr_stream_arbiter

Interface
REQ-001 Parameter NUM_STREAMS, default 4, number of plaintext requesters sharing one AES-256-CTR core (2..8).
REQ-002 Parameter DATA_WIDTH, default 128, AXI-Stream beat width.
REQ-003 Parameter ID_FIFO_DEPTH, default 8, number of packets in flight inside the core (power of 2).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 s_axis_tdata  in  NUM_STREAMS*DATA_WIDTH  requester plaintext; stream i in slice i.
REQ-007 s_axis_tvalid / s_axis_tlast  in  NUM_STREAMS  per-requester valid / end-of-packet.
REQ-008 s_axis_tready  out  NUM_STREAMS  per-requester ready.
REQ-009 m_axis_tdata / tvalid / tlast  out  DATA_WIDTH/1/1  plaintext to core; m_axis_tready in 1.
REQ-010 m_axis_tuser  out  ID_W  granted stream id; ID_W = max(1, clog2(NUM_STREAMS)).
REQ-011 c_axis_tdata / tvalid / tlast  in  DATA_WIDTH/1/1  ciphertext from core; c_axis_tready out 1.
REQ-012 o_axis_tdata  out  NUM_STREAMS*DATA_WIDTH; o_axis_tvalid / o_axis_tlast out NUM_STREAMS; o_axis_tready in NUM_STREAMS  ciphertext returned to owner.
REQ-013 busy out 1 (FSM not IDLE); protocol_err out 1 (sticky).

Function
REQ-014 FSM states IDLE, GRANT, LOCK; reset state IDLE.
REQ-015 IDLE: if any s_axis_tvalid and ID FIFO not full -> select winner, register grant_id, push grant_id to ID FIFO, go GRANT; else stay.
REQ-016 Winner = first valid stream searching round-robin from last_grant+1 modulo NUM_STREAMS; last_grant resets to NUM_STREAMS-1 (stream 0 wins first).
REQ-017 GRANT: unconditional one-cycle transition to LOCK; arbitration latency from tvalid to first m_axis_tvalid = 2 cycles.
REQ-018 LOCK: m_axis_* = granted stream combinationally; s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0; m_axis_tuser = grant_id.
REQ-019 LOCK exit on m handshake with tlast -> IDLE, last_grant <= grant_id; grant never changes mid-packet.
REQ-020 Outside LOCK: m_axis_tvalid = 0, all s_axis_tready = 0.
REQ-021 Return path: head of ID FIFO selects owner h; o_axis_tvalid[h] = c_axis_tvalid; c_axis_tready = o_axis_tready[h]; all other o_axis_tvalid = 0; o_axis_tdata broadcast to all slices.
REQ-022 ID FIFO pop on c handshake with c_axis_tlast; push and pop in same cycle permitted, count unchanged.
REQ-023 ID FIFO empty -> c_axis_tready = 0, all o_axis_tvalid = 0; c_axis_tvalid high while empty sets protocol_err.
REQ-024 ID FIFO full -> no new grant; packet already in LOCK completes normally.
REQ-025 Single-beat packet (tvalid and tlast on first beat) is legal on both paths.
REQ-026 Backpressure on o_axis_tready[h] stalls only the core return path, never forward arbitration unless the FIFO fills.

Reset
REQ-027 rst clears FSM to IDLE, ID FIFO to empty, protocol_err to 0, last_grant to NUM_STREAMS-1.
REQ-028 During and one cycle after rst: all tready/tvalid outputs 0, busy 0.
REQ-029 rst mid-packet drops the packet; no partial state survives; core flush is the integrator's responsibility.

Structure
REQ-030 Package ctr_arb_pkg holds the state enum (IDLE, GRANT, LOCK) and the ID_W width function.
REQ-031 Sub-module stream_id_fifo (synchronous FIFO, ID_W wide, ID_FIFO_DEPTH deep, full/empty flags) holds return routing.

Verification
REQ-032 Streams 0..3 all valid with 2-beat packets, m_axis_tready=1 -> grant order 0,1,2,3,0; tuser matches; each packet 2+2 cycles.
REQ-033 Stream 2 packet of 5 beats, stream 1 asserts valid at beat 2 -> stream 1 waits until stream 2 tlast; no interleaving on m_axis.
REQ-034 Loopback core with 10-cycle latency, 3 streams interleaved -> each o_axis stream receives exactly its own beats in order, tlast aligned.
REQ-035 ID_FIFO_DEPTH=2, core return stalled (o_axis_tready=0) -> third packet not granted, busy=0 in IDLE until one pop.
REQ-036 c_axis_tvalid=1 with FIFO empty -> c_axis_tready=0, protocol_err=1 and stays 1 until rst.
REQ-037 rst asserted at beat 3 of an 8-beat packet -> next cycle all readies 0, FIFO empty, next grant goes to stream 0.
